mem_wb_pipe: RTL and testbench

- Parametrised successor to the single-stage MEM/WB register.
- A chain of STAGES identical pipeline registers carrying writeback payload (result, update word, destination, write-enable, super flag) from the MEM stage to the register file.
- Adds per-stage valid bits, stall (hold), flush (bubble insertion), a youngest-first forwarding lookup across all stages, and a saturating stall-cycle counter.

---
 rtl/mem_wb_pipe_if.sv | 48 ++++
 rtl/mem_wb_pipe.sv | 106 ++++++++++
 tb/tb_mem_wb_pipe.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if
// Groups the MEM/WB pipe traffic into one bundle. The clock and reset are not
// part of it.
//   In_*          writeback payload offered by the MEM stage
//   Stall, Flush  pipeline control
//   Query_Reg     register index for the forwarding lookup
//   Out_*         payload leaving the last stage, headed for the register file
//   Query_*       forwarding lookup result
//   Stall_Count   saturating count of stalled cycles
// The master modport drives the pipe. The slave modport is the pipe itself.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
);
  logic              In_Valid;
  logic [DATA_W-1:0] In_Result;
  logic [DATA_W-1:0] In_Update;
  logic [DEST_W-1:0] In_RegDst;
  logic              In_RegWrite;
  logic              In_Super;
  logic              Stall;
  logic              Flush;
  logic [DEST_W-1:0] Query_Reg;
  logic              Out_Valid;
  logic [DATA_W-1:0] Out_Result;
  logic [DATA_W-1:0] Out_Update;
  logic [DEST_W-1:0] Out_RegDst;
  logic              Out_RegWrite;
  logic              Out_Super;
  logic              Query_Hit;
  logic [DATA_W-1:0] Query_Data;
  logic [CNT_W-1:0]  Stall_Count;

  modport master (
    output In_Valid, In_Result, In_Update, In_RegDst, In_RegWrite, In_Super,
    output Stall, Flush, Query_Reg,
    input  Out_Valid, Out_Result, Out_Update, Out_RegDst, Out_RegWrite, Out_Super,
    input  Query_Hit, Query_Data, Stall_Count
  );

  modport slave (
    input  In_Valid, In_Result, In_Update, In_RegDst, In_RegWrite, In_Super,
    input  Stall, Flush, Query_Reg,
    output Out_Valid, Out_Result, Out_Update, Out_RegDst, Out_RegWrite, Out_Super,
    output Query_Hit, Query_Data, Stall_Count
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe
// Multi-stage MEM/WB pipeline register with the following features:
//   - a valid bit for each stage
//   - stall, which holds every stage
//   - flush, which clears every stage
//   - a forwarding lookup that searches from the youngest stage first
//   - a saturating counter of stalled cycles
// Ports:
//   Clk  rising-edge clock
//   Rst  synchronous reset, active low
//   bus  mem_wb_pipe_if.slave. It carries In_*, Stall, Flush, Query_Reg,
//        Out_*, Query_Hit, Query_Data and Stall_Count.
// DATA_W, DEST_W and CNT_W must match the parameters of the connected interface.
// The latency from capture to Out_* is STAGES edges. STAGES must be 1 to 4.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  mem_wb_pipe_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] update;
    logic [DEST_W-1:0] reg_dst;
    logic              reg_write;
    logic              super_flag;
  } stage_t;

  stage_t            stage_reg [STAGES];
  stage_t            stage_src [STAGES];   // value each stage loads on advance
  logic [STAGES-1:0] match_vec;
  logic [DATA_W-1:0] query_data_next;
  logic [CNT_W-1:0]  stall_cnt_reg;

  // Stage 0 loads the input slot and stage k loads stage k-1. The payload is
  // captured even when In_Valid is low, which matches the legacy register.
  // A match needs a valid entry that writes, a matching destination, and a
  // nonzero query index, because r0 is never forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_src[gi] = {bus.In_Valid, bus.In_Result, bus.In_Update,
                                bus.In_RegDst, bus.In_RegWrite, bus.In_Super};
      end else begin : g_tail
        assign stage_src[gi] = stage_reg[gi-1];
      end

      assign match_vec[gi] = stage_reg[gi].valid && stage_reg[gi].reg_write &&
                             (stage_reg[gi].reg_dst == bus.Query_Reg) &&
                             (bus.Query_Reg != '0);
    end
  endgenerate

  // Reset and flush both produce an all-zero pipe. Stall freezes every stage,
  // and the input slot is dropped, not queued.
  always_ff @(posedge Clk) begin
    if (!Rst || bus.Flush) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (!bus.Stall) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= stage_src[i];
      end
    end
  end

  // Stall_Count also counts cycles where flush wins over stall, because the
  // stall request was still raised. The counter sticks at its maximum value.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt_reg <= '0;
    end else if (bus.Stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  // Scan from oldest to youngest so the youngest match writes last and wins.
  always_comb begin
    query_data_next = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        query_data_next = stage_reg[i].result;
      end
    end
  end

  assign bus.Out_Valid    = stage_reg[STAGES-1].valid;
  assign bus.Out_Result   = stage_reg[STAGES-1].result;
  assign bus.Out_Update   = stage_reg[STAGES-1].update;
  assign bus.Out_RegDst   = stage_reg[STAGES-1].reg_dst;
  // A bubble can still hold RegWrite=1 in its payload, so gate the write with valid.
  assign bus.Out_RegWrite = stage_reg[STAGES-1].reg_write & stage_reg[STAGES-1].valid;
  assign bus.Out_Super    = stage_reg[STAGES-1].super_flag;
  assign bus.Query_Hit    = |match_vec;
  assign bus.Query_Data   = query_data_next;
  assign bus.Stall_Count  = stall_cnt_reg;

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;
  localparam int DATA_W = 32;
  localparam int DEST_W = 5;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [31:0] res;
    logic [31:0] upd;
    logic [4:0]  dst;
    logic        we;
    logic        sup;
  } exp_t;

  logic Clk;
  logic Rst;
  int   checks = 0;
  int   errors = 0;
  logic adv_q  = 1'b0;
  exp_t exp_q[$];

  mem_wb_pipe_if #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) bus ();

  mem_wb_pipe #(.DATA_W(DATA_W), .DEST_W(DEST_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Remember whether the last edge advanced the pipe. A stall leaves the same
  // entry on the outputs, and that entry must not be consumed twice.
  always @(posedge Clk) adv_q <= Rst && !bus.Flush && !bus.Stall;

  always @(negedge Clk) begin
    exp_t e;
    if (adv_q && bus.Out_Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=res 0x%0h dst %0d required=nothing", bus.Out_Result, bus.Out_RegDst);
      end else begin
        e = exp_q.pop_front();
        $display("OUT res=0x%0h upd=0x%0h dst=%0d we=%0b sup=%0b", bus.Out_Result, bus.Out_Update, bus.Out_RegDst, bus.Out_RegWrite, bus.Out_Super);
        check("sb_result", bus.Out_Result, e.res);
        check("sb_update", bus.Out_Update, e.upd);
        check("sb_regdst", 32'(bus.Out_RegDst), 32'(e.dst));
        check("sb_regwrite", 32'(bus.Out_RegWrite), 32'(e.we));
        check("sb_super", 32'(bus.Out_Super), 32'(e.sup));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] res, input logic [31:0] upd,
                        input logic [4:0] dst, input logic we, input logic sup, input bit push);
    exp_t e;
    bus.In_Valid    = v;
    bus.In_Result   = res;
    bus.In_Update   = upd;
    bus.In_RegDst   = dst;
    bus.In_RegWrite = we;
    bus.In_Super    = sup;
    if (push) begin
      e.res = res; e.upd = upd; e.dst = dst; e.we = we; e.sup = sup;
      exp_q.push_back(e);
      $display("IN  res=0x%0h upd=0x%0h dst=%0d we=%0b sup=%0b", res, upd, dst, we, sup);
    end
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic query(input string name, input logic [4:0] r, input logic hit, input logic [31:0] data);
    bus.Query_Reg = r;
    #1;
    check({name, "_hit"}, 32'(bus.Query_Hit), 32'(hit));
    check({name, "_data"}, bus.Query_Data, data);
    bus.Query_Reg = 5'd0;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, 32'(bus.Out_Valid), 32'd0);
    check({name, "_result"}, bus.Out_Result, 32'd0);
    check({name, "_update"}, bus.Out_Update, 32'd0);
    check({name, "_regdst"}, 32'(bus.Out_RegDst), 32'd0);
    check({name, "_regwrite"}, 32'(bus.Out_RegWrite), 32'd0);
    check({name, "_super"}, 32'(bus.Out_Super), 32'd0);
  endtask

  initial begin
    Rst = 1'b0;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    bus.Query_Reg = 5'd0;
    idle();

    // Reset for two cycles.
    tick();
    tick();
    check_zero_outputs("reset");
    check("reset_cnt", 32'(bus.Stall_Count), 32'd0);
    query("reset_q", 5'd5, 1'b0, 32'h0);

    // Single entry, latency 3.
    Rst = 1'b1;
    set_in(1'b1, 32'hDEADBEEF, 32'h00001234, 5'd5, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    check("lat_e1_valid", 32'(bus.Out_Valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(bus.Out_Valid), 32'd0);
    tick();
    check("lat_e3_valid", 32'(bus.Out_Valid), 32'd1);
    check("lat_e3_result", bus.Out_Result, 32'hDEADBEEF);
    check("lat_e3_regdst", 32'(bus.Out_RegDst), 32'd5);
    check("lat_e3_regwrite", 32'(bus.Out_RegWrite), 32'd1);
    tick();
    check("lat_e4_valid", 32'(bus.Out_Valid), 32'd0);
    check("lat_e4_regwrite", 32'(bus.Out_RegWrite), 32'd0);

    // Stall for two cycles after result 2 has been captured.
    set_in(1'b1, 32'd1, 32'h10, 5'd1, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 32'd2, 32'h20, 5'd2, 1'b1, 1'b0, 1'b1);
    tick();
    bus.Stall = 1'b1;
    set_in(1'b1, 32'h99, 32'h99, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_out_valid", 32'(bus.Out_Valid), 32'd0);
      check("stall_out_result", bus.Out_Result, 32'd0);
      query("stall_q1", 5'd1, 1'b1, 32'd1);
    end
    check("stall_cnt2", 32'(bus.Stall_Count), 32'd2);
    bus.Stall = 1'b0;
    set_in(1'b1, 32'd3, 32'h30, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    check("stall_out1", bus.Out_Result, 32'd1);
    set_in(1'b1, 32'd4, 32'h40, 5'd4, 1'b1, 1'b0, 1'b1);
    tick();
    check("stall_out2", bus.Out_Result, 32'd2);
    idle();
    tick();
    check("stall_out3", bus.Out_Result, 32'd3);
    bus.Stall = 1'b1;
    tick();
    check("hold_valid", 32'(bus.Out_Valid), 32'd1);
    check("hold_result", bus.Out_Result, 32'd3);
    check("stall_cnt3", 32'(bus.Stall_Count), 32'd3);
    bus.Stall = 1'b0;
    tick();
    check("stall_out4", bus.Out_Result, 32'd4);
    tick();
    check("stall_drained", 32'(bus.Out_Valid), 32'd0);

    // Flush and Stall together while an input is offered.
    set_in(1'b1, 32'hA1, 32'h1, 5'd8, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 32'hB2, 32'h2, 5'd9, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 32'hC3, 32'h3, 5'd10, 1'b1, 1'b1, 1'b1);
    tick();
    bus.Flush = 1'b1;
    bus.Stall = 1'b1;
    set_in(1'b1, 32'hEE, 32'hEE, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    check_zero_outputs("flush");
    query("flush_q9", 5'd9, 1'b0, 32'h0);
    check("flush_cnt", 32'(bus.Stall_Count), 32'd4);
    check("flush_inflight", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    bus.Flush = 1'b0;
    bus.Stall = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_stale", 32'(bus.Out_Valid), 32'd0);
    end

    // Forwarding priority, r0, RegWrite=0, and an invalid entry with RegWrite=1.
    set_in(1'b1, 32'h22, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    query("fwd_only_old", 5'd7, 1'b1, 32'h22);
    set_in(1'b1, 32'h33, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 32'h11, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    query("fwd_youngest", 5'd7, 1'b1, 32'h11);
    query("fwd_no_we", 5'd3, 1'b0, 32'h0);
    query("fwd_none", 5'd12, 1'b0, 32'h0);
    set_in(1'b1, 32'h44, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    query("fwd_r0", 5'd0, 1'b0, 32'h0);
    query("fwd_mid", 5'd7, 1'b1, 32'h11);
    set_in(1'b0, 32'h66, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    query("fwd_invalid", 5'd6, 1'b0, 32'h0);
    idle();
    tick();
    tick();
    check("bubble_valid", 32'(bus.Out_Valid), 32'd0);
    check("bubble_regwrite", 32'(bus.Out_RegWrite), 32'd0);
    check("bubble_regdst", 32'(bus.Out_RegDst), 32'd6);
    tick();

    // Saturation of the stall counter. It starts at 4 here.
    bus.Stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) check("sat_cnt14", 32'(bus.Stall_Count), 32'd14);
      if (k == 11) check("sat_cnt15", 32'(bus.Stall_Count), 32'd15);
    end
    check("sat_cnt_hold", 32'(bus.Stall_Count), 32'd15);
    Rst = 1'b0;
    tick();
    check("sat_reset_cnt", 32'(bus.Stall_Count), 32'd0);
    Rst = 1'b1;
    bus.Stall = 1'b0;

    // Reset while entries are in flight and Stall is high.
    set_in(1'b1, 32'h101, 32'h5, 5'd1, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 32'h202, 32'h6, 5'd2, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 32'h303, 32'h7, 5'd3, 1'b1, 1'b1, 1'b1);
    tick();
    Rst = 1'b0;
    bus.Stall = 1'b1;
    set_in(1'b1, 32'h404, 32'h8, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    check_zero_outputs("midrst");
    check("midrst_cnt", 32'(bus.Stall_Count), 32'd0);
    query("midrst_q2", 5'd2, 1'b0, 32'h0);
    check("midrst_inflight", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    Rst = 1'b1;
    bus.Stall = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midrst_no_stale", 32'(bus.Out_Valid), 32'd0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
